// File: rtl/clock_ratio_meter.sv
// clock_ratio_meter
//   Measures the period of a slow asynchronous signal (SIG_IN) in CLK_IN
//   cycles. SIG_IN is synchronized by two flops; a rising edge is
//   synchronized-now = 1 with previous = 0. One measurement spans two
//   detected edges. In continuous mode the closing edge also opens the next
//   period. A period that reaches the counter maximum without an edge is
//   reported as all ones with OVERFLOW set.
//
//   Optional build macro: CLOCK_RATIO_METER_TIMEOUT_EN
//     defined     : ARM gives up after 2^CNT_W-1 cycles without an edge and
//                   reports all ones with OVERFLOW set.
//     not defined : ARM waits for the first edge indefinitely.
//
// Ports
//   CLK_IN     in   system clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   SIG_IN     in   signal being measured (asynchronous)
//   START      in   measurement request, sampled only in IDLE
//   CONT       in   continuous (back-to-back) measurement mode
//   BUSY       out  1 whenever the FSM is not in IDLE
//   VALID      out  one-cycle pulse when PERIOD_OUT/OVERFLOW update
//   PERIOD_OUT out  last measured period in CLK_IN cycles
//   OVERFLOW   out  last result saturated
module clock_ratio_meter #(
   parameter int CNT_W = 16
) (
   input  logic             CLK_IN,
   input  logic             RST_N,
   input  logic             SIG_IN,
   input  logic             START,
   input  logic             CONT,
   output logic             BUSY,
   output logic             VALID,
   output logic [CNT_W-1:0] PERIOD_OUT,
   output logic             OVERFLOW
);

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      COUNT
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           state, state_nxt;
   logic             sync1, sync2, sig_prev;
   logic             sig_edge;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [CNT_W-1:0] period_nxt;
   logic             ovf_nxt;
   logic             valid_nxt;
`ifdef CLOCK_RATIO_METER_TIMEOUT_EN
   logic [CNT_W-1:0] arm_cnt, arm_cnt_nxt;
`endif

   // Synchronizer plus previous-value register for edge detection.
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         sig_prev <= 1'b0;
      end else begin
         sync1    <= SIG_IN;
         sync2    <= sync1;
         sig_prev <= sync2;
      end
   end

   assign sig_edge = sync2 & ~sig_prev;

   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         state      <= IDLE;
         cnt        <= '0;
         PERIOD_OUT <= '0;
         OVERFLOW   <= 1'b0;
         VALID      <= 1'b0;
`ifdef CLOCK_RATIO_METER_TIMEOUT_EN
         arm_cnt    <= '0;
`endif
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         PERIOD_OUT <= period_nxt;
         OVERFLOW   <= ovf_nxt;
         VALID      <= valid_nxt;
`ifdef CLOCK_RATIO_METER_TIMEOUT_EN
         arm_cnt    <= arm_cnt_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      period_nxt  = PERIOD_OUT;
      ovf_nxt     = OVERFLOW;
      valid_nxt   = 1'b0;
`ifdef CLOCK_RATIO_METER_TIMEOUT_EN
      arm_cnt_nxt = arm_cnt;
`endif
      case (state)
         IDLE: begin
            if (START) begin
               state_nxt   = ARM;
`ifdef CLOCK_RATIO_METER_TIMEOUT_EN
               // Counts ARM cycles including the first one.
               arm_cnt_nxt = CNT_ONE;
`endif
            end
         end
         ARM: begin
            if (sig_edge) begin
               cnt_nxt   = CNT_ONE;
               state_nxt = COUNT;
            end
`ifdef CLOCK_RATIO_METER_TIMEOUT_EN
            else if (arm_cnt == CNT_MAX) begin
               period_nxt = CNT_MAX;
               ovf_nxt    = 1'b1;
               valid_nxt  = 1'b1;
               state_nxt  = IDLE;
            end else begin
               arm_cnt_nxt = arm_cnt + 1'b1;
            end
`endif
         end
         COUNT: begin
            // An edge takes priority over saturation at the same cycle.
            if (sig_edge) begin
               period_nxt = cnt;
               ovf_nxt    = 1'b0;
               valid_nxt  = 1'b1;
               if (CONT) begin
                  cnt_nxt = CNT_ONE;
               end else begin
                  state_nxt = IDLE;
               end
            end else if (cnt == CNT_MAX) begin
               period_nxt = CNT_MAX;
               ovf_nxt    = 1'b1;
               valid_nxt  = 1'b1;
               state_nxt  = IDLE;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign BUSY = (state != IDLE);

endmodule

// File: doc/clock_ratio_meter.md
# clock_ratio_meter

Measures the period of a slow, asynchronous clock-like signal in cycles of the system clock and reports it as a count. It is the receiving end of the divided-clock path: the divider produces a slow clock from `CLK_IN`, and this block recovers the division ratio from that slow clock. Uses include self-checking clock trees, board-level frequency checks, and run-time detection of a stopped slow clock.

## Interface
Parameters:
- `CNT_W`, default 16: width of the period counter and of `PERIOD_OUT`. Must be 2 or greater.

Ports:
- `CLK_IN`, input, 1 bit: system clock. All state updates on its rising edge.
- `RST_N`, input, 1 bit: asynchronous, active-low reset.
- `SIG_IN`, input, 1 bit: signal being measured. Asynchronous to `CLK_IN`.
- `START`, input, 1 bit: request a measurement. Sampled only in IDLE.
- `CONT`, input, 1 bit: continuous mode. When 1, the block re-measures back-to-back.
- `BUSY`, output, 1 bit: 1 in any state other than IDLE.
- `VALID`, output, 1 bit: one-cycle pulse when `PERIOD_OUT` and `OVERFLOW` are updated.
- `PERIOD_OUT`, output, `CNT_W` bits: last measured period, in `CLK_IN` cycles.
- `OVERFLOW`, output, 1 bit: 1 if the last result saturated; cleared by the next non-saturated result.

## Operation
- **Synchronizer:** a 2-flop synchronizer on `SIG_IN`, followed by a previous-value register. A detected rising edge (`EDGE`) is synchronized-now = 1 and previous = 0. All three flops reset to 0.
- **FSM states:** IDLE, ARM, COUNT.
- **IDLE:**
  - `START`=1 moves to ARM.
  - `EDGE` is ignored.
- **ARM:**
  - On `EDGE`: counter <= 1, move to COUNT.
  - Otherwise wait (see Configuration).
- **COUNT, no `EDGE`:**
  - If counter < 2^CNT_W−1: counter <= counter+1.
  - If counter == 2^CNT_W−1: `PERIOD_OUT` <= all ones, `OVERFLOW` <= 1, `VALID` pulse, move to IDLE. The block goes to IDLE even when `CONT`=1.
- **COUNT, on `EDGE`:**
  - `PERIOD_OUT` <= counter, `OVERFLOW` <= 0, `VALID` pulse.
  - If `CONT`=1: counter <= 1 and stay in COUNT. The same edge starts the next period.
  - Otherwise move to IDLE.
- **Simultaneous `EDGE` and counter at maximum:** the edge wins. The result is a valid period of 2^CNT_W−1 with `OVERFLOW`=0.
- **`START` while `BUSY`=1:** ignored. It is not queued.
- **`CONT` deasserted in COUNT:** the current period completes and reports, then the block moves to IDLE.
- **Reset (asynchronous, including mid-measurement):**
  - State goes to IDLE, counter to 0.
  - `BUSY`=0, `VALID`=0, `PERIOD_OUT`=0, `OVERFLOW`=0.
  - Synchronizer flops go to 0.
- **Reset release with `SIG_IN` high:** produces an `EDGE` about 2 cycles later. It is discarded because the block is in IDLE.
- **Accuracy:** ±1 cycle from synchronizer phase. `SIG_IN` high and low times must each be at least 2 `CLK_IN` cycles. Faster inputs are out of scope and give undefined results.

## Timing
- **`START` to `BUSY`:** `START` sampled high in IDLE at edge k gives `BUSY`=1 from k+1.
- **`SIG_IN` to `EDGE`:** `EDGE` is asserted 2 to 3 `CLK_IN` edges after the `SIG_IN` rise.
- **Result timing:** the `EDGE` that ends a period at edge m gives `VALID`=1 during cycle m+1, with `PERIOD_OUT` and `OVERFLOW` already updated in that cycle. In single-shot mode `BUSY`=0 in the same cycle.
- **Output hold:** `PERIOD_OUT` and `OVERFLOW` hold until the next `VALID`.
- **Continuous mode:** `VALID` repeats once per `SIG_IN` period, with no dead cycles between measurements.
- **Period definition:** for detected edges at `CLK_IN` cycles t and t+P, `PERIOD_OUT`=P.

## Configuration
- **`CLOCK_RATIO_METER_TIMEOUT_EN` defined:**
  - ARM carries its own counter. If 2^CNT_W−1 cycles pass without `EDGE`, then `PERIOD_OUT` <= all ones, `OVERFLOW` <= 1, `VALID` pulse, move to IDLE.
  - A stopped `SIG_IN` is therefore always reported.
- **`CLOCK_RATIO_METER_TIMEOUT_EN` not defined:**
  - ARM waits indefinitely for the first edge. Only reset leaves ARM.
  - No ARM timeout logic is built.

## Test plan
- **Single-shot ratio 4:** `SIG_IN` driven by a divide-by-4 of `CLK_IN`, pulse `START`. Expect exactly one `VALID`, `PERIOD_OUT`=4, `OVERFLOW`=0, and `BUSY` low in the `VALID` cycle.
- **Continuous ratio 8:** `SIG_IN` driven by a divide-by-8, `CONT`=1. Expect `VALID` every 8 cycles with `PERIOD_OUT`=8. Drop `CONT`: one more `VALID`, then `BUSY`=0.
- **Overflow:** `CNT_W`=8; after the first `EDGE`, hold `SIG_IN` low. Expect `VALID` with `PERIOD_OUT`=255 and `OVERFLOW`=1, then IDLE. A following good measurement clears `OVERFLOW`.
- **Ignored `START`:** pulse `START` while in COUNT. Expect no restart, no extra `VALID`, and the result unchanged from the single-shot case.
- **Mid-measurement reset:** assert `RST_N`=0 in COUNT. Expect all outputs to be 0 immediately, asynchronously. After release with `SIG_IN` high, expect no `VALID` without `START`.
- **Timeout:** with `CLOCK_RATIO_METER_TIMEOUT_EN`, `CNT_W`=8, `SIG_IN` stuck low, `START` pulsed. Expect `VALID` with `OVERFLOW`=1 and `PERIOD_OUT`=255 after 255 ARM cycles. Without the macro, expect `BUSY` to stay 1 and no `VALID`.
